// File: rtl/hwlp_iv_gen_if.sv
// Configuration, control and IV-tuple signals of the hardware-loop IV generator.
// The master side configures and launches the nest; the slave side is the generator.
interface hwlp_iv_gen_if #(
  parameter int N_LP       = 4,
  parameter int NBIT_LP_IV = 8
);
  logic                         start_i;
  logic                         stall_i;
  logic [$clog2(N_LP+1)-1:0]    n_lp_i;
  logic [N_LP*NBIT_LP_IV-1:0]   lp_start_i;
  logic [N_LP*NBIT_LP_IV-1:0]   lp_end_i;
  logic [N_LP*NBIT_LP_IV-1:0]   lp_stride_i;
  logic [N_LP*NBIT_LP_IV-1:0]   loop_vars_o;
  logic                         hwlp_valid_o;
  logic [N_LP-1:0]              end_condition_lp_o;
  logic                         end_lp_o;
  logic                         busy_o;

  modport master (
    output start_i, stall_i, n_lp_i, lp_start_i, lp_end_i, lp_stride_i,
    input  loop_vars_o, hwlp_valid_o, end_condition_lp_o, end_lp_o, busy_o
  );

  modport slave (
    input  start_i, stall_i, n_lp_i, lp_start_i, lp_end_i, lp_stride_i,
    output loop_vars_o, hwlp_valid_o, end_condition_lp_o, end_lp_o, busy_o
  );
endinterface

// File: rtl/hwlp_iv_gen.sv
// Hardware-loop induction-variable generator: walks a nest of up to N_LP counted loops
// (loop 0 innermost) and emits one IV tuple per unstalled cycle with end-condition flags.
module hwlp_iv_gen #(
  parameter int N_LP       = 4,
  parameter int NBIT_LP_IV = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  hwlp_iv_gen_if.slave    bus
);
  localparam int NW = $clog2(N_LP+1);
  localparam int NB = NBIT_LP_IV;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_r, state_s;
  logic [NB-1:0]   iv_r     [N_LP];
  logic [NB-1:0]   iv_s     [N_LP];
  logic [NB-1:0]   start_r  [N_LP];
  logic [NB-1:0]   end_r    [N_LP];
  logic [NB-1:0]   stride_r [N_LP];
  logic [NW-1:0]   n_lp_r;
  logic [NW-1:0]   n_lp_eff_s;
  logic [N_LP-1:0] ec_s;
  logic [N_LP-1:0] carry_s;
  logic            load_s;
  logic            adv_s;

  // End conditions from registered state; the extra MSB keeps iv+stride from wrapping.
  always_comb begin
    ec_s = '0;
    for (int k = 0; k < N_LP; k++) begin
      if (NW'(k) < n_lp_r) begin
        ec_s[k] = ({1'b0, iv_r[k]} + {1'b0, stride_r[k]}) >= {1'b0, end_r[k]};
      end else begin
        ec_s[k] = 1'b1;
      end
    end
  end

  // Ripple carry: loop k steps only when every inner loop is on its last iteration.
  always_comb begin
    carry_s    = '0;
    carry_s[0] = 1'b1;
    for (int k = 1; k < N_LP; k++) begin
      carry_s[k] = carry_s[k-1] & ec_s[k-1];
    end
  end

  // Clamp the requested loop count into 1..N_LP.
  always_comb begin
    if (bus.n_lp_i == '0) begin
      n_lp_eff_s = NW'(1);
    end else if (bus.n_lp_i > NW'(N_LP)) begin
      n_lp_eff_s = NW'(N_LP);
    end else begin
      n_lp_eff_s = bus.n_lp_i;
    end
  end

  assign adv_s = (state_r == RUN) & bus.start_i & ~bus.stall_i;

  // Next-state and next-IV logic; abort (start low) takes priority over stall and advance.
  always_comb begin
    state_s = state_r;
    iv_s    = iv_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          state_s = RUN;
          load_s  = 1'b1;
          for (int k = 0; k < N_LP; k++) begin
            iv_s[k] = bus.lp_start_i[k*NB +: NB];
          end
        end else begin
          iv_s = '{default: '0};
        end
      end
      RUN: begin
        if (!bus.start_i) begin
          state_s = IDLE;
          iv_s    = '{default: '0};
        end else if (bus.stall_i) begin
          state_s = RUN;
        end else begin
          for (int k = 0; k < N_LP; k++) begin
            if (carry_s[k] && ec_s[k]) begin
              iv_s[k] = start_r[k];
            end else if (carry_s[k]) begin
              iv_s[k] = iv_r[k] + stride_r[k];
            end else begin
              iv_s[k] = iv_r[k];
            end
          end
          if (&ec_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      DONE: begin
        if (!bus.start_i) begin
          state_s = IDLE;
          iv_s    = '{default: '0};
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        iv_s    = '{default: '0};
      end
    endcase
  end

  // State and IV registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      iv_r    <= '{default: '0};
    end else begin
      state_r <= state_s;
      iv_r    <= iv_s;
    end
  end

  // Configuration captured once at launch; zero strides become 1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      n_lp_r   <= '0;
      start_r  <= '{default: '0};
      end_r    <= '{default: '0};
      stride_r <= '{default: '0};
    end else if (load_s) begin
      n_lp_r <= n_lp_eff_s;
      for (int k = 0; k < N_LP; k++) begin
        start_r[k]  <= bus.lp_start_i[k*NB +: NB];
        end_r[k]    <= bus.lp_end_i[k*NB +: NB];
        stride_r[k] <= (bus.lp_stride_i[k*NB +: NB] == '0) ? NB'(1) : bus.lp_stride_i[k*NB +: NB];
      end
    end
  end

  // Output drive: IV tuple straight from registers, flags qualified by valid.
  always_comb begin
    bus.loop_vars_o = '0;
    for (int k = 0; k < N_LP; k++) begin
      bus.loop_vars_o[k*NB +: NB] = iv_r[k];
    end
    bus.hwlp_valid_o       = adv_s;
    bus.end_condition_lp_o = adv_s ? ec_s : '0;
    bus.end_lp_o           = adv_s & (&ec_s);
    bus.busy_o             = (state_r == RUN);
  end
endmodule

// File: tb/tb_hwlp_iv_gen.sv
// Directed table-driven bench for hwlp_iv_gen with N_LP=2, NBIT_LP_IV=8.
module tb_hwlp_iv_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hwlp_iv_gen_if #(.N_LP(2), .NBIT_LP_IV(8)) bus ();
  hwlp_iv_gen #(.N_LP(2), .NBIT_LP_IV(8)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  typedef struct {
    logic [1:0] n;
    logic [7:0] s0, e0, t0, s1, e1, t1;
  } cfg_t;

  typedef struct {
    cfg_t       c;
    logic       start, stall;
    logic       v;
    logic [7:0] iv0, iv1;
    logic [1:0] ec;
    logic       en, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(cfg_t c, logic st, logic sl, logic v, logic [7:0] iv0,
                              logic [7:0] iv1, logic [1:0] ec, logic en, logic bz);
    vec_t r;
    r.c = c; r.start = st; r.stall = sl; r.v = v; r.iv0 = iv0; r.iv1 = iv1;
    r.ec = ec; r.en = en; r.busy = bz;
    return r;
  endfunction

  task automatic apply_cfg(cfg_t c);
    bus.n_lp_i      = c.n;
    bus.lp_start_i  = {c.s1, c.s0};
    bus.lp_end_i    = {c.e1, c.e0};
    bus.lp_stride_i = {c.t1, c.t0};
  endtask

  function automatic logic [20:0] obs();
    return {bus.hwlp_valid_o, bus.loop_vars_o[15:8], bus.loop_vars_o[7:0],
            bus.end_condition_lp_o, bus.end_lp_o, bus.busy_o};
  endfunction

  task automatic chk(string name, logic [20:0] act, logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {v,iv1,iv0,ec,end,busy}=%h required %h", name, act, exp);
    end
  endtask

  initial begin
    cfg_t a, d, w, z, junk;
    a    = '{n: 2'd2, s0: 8'd0,   e0: 8'd3,   t0: 8'd1, s1: 8'd0, e1: 8'd2,   t1: 8'd1};
    d    = '{n: 2'd1, s0: 8'd5,   e0: 8'd4,   t0: 8'd1, s1: 8'd7, e1: 8'd9,   t1: 8'd1};
    w    = '{n: 2'd1, s0: 8'd250, e0: 8'd255, t0: 8'd4, s1: 8'd0, e1: 8'd0,   t1: 8'd0};
    z    = '{n: 2'd0, s0: 8'd0,   e0: 8'd2,   t0: 8'd0, s1: 8'd3, e1: 8'd5,   t1: 8'd1};
    junk = '{n: 2'd1, s0: 8'd9,   e0: 8'd200, t0: 8'd7, s1: 8'd4, e1: 8'd100, t1: 8'd3};

    // basic 3x2 nest, then DONE holding with start high, then back to IDLE
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0, 2'b01, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd0, 8'd1, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1, 2'b11, 1'b1, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    // same nest with a 2-cycle stall after the first tuple
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0, 2'b01, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd0, 8'd1, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1, 2'b11, 1'b1, 1'b1));
    tbl.push_back(mk(a, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    // degenerate loop (start >= end) runs exactly once; inactive loop 1 shows its start
    tbl.push_back(mk(d, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(d, 1'b1, 1'b0, 1'b1, 8'd5, 8'd7, 2'b11, 1'b1, 1'b1));
    tbl.push_back(mk(d, 1'b0, 1'b0, 1'b0, 8'd5, 8'd7, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(d, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    // near-overflow bound: 250, 254 and no wrap
    tbl.push_back(mk(w, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(w, 1'b1, 1'b0, 1'b1, 8'd250, 8'd0, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(w, 1'b1, 1'b0, 1'b1, 8'd254, 8'd0, 2'b11, 1'b1, 1'b1));
    tbl.push_back(mk(w, 1'b0, 1'b0, 1'b0, 8'd250, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(w, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0, 2'b00, 1'b0, 1'b0));
    // abort after the second tuple, relaunch from (0,0), abort again
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(a, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(a, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    // n_lp=0 counts as one loop, stride 0 counts as 1
    tbl.push_back(mk(z, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(z, 1'b1, 1'b0, 1'b1, 8'd0, 8'd3, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(z, 1'b1, 1'b0, 1'b1, 8'd1, 8'd3, 2'b11, 1'b1, 1'b1));
    tbl.push_back(mk(z, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(z, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0));

    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    apply_cfg(a);
    repeat (2) @(posedge clk);
    #1 chk("reset_state", obs(), 21'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      apply_cfg(tbl[i].c);
      bus.start_i = tbl[i].start;
      bus.stall_i = tbl[i].stall;
      #1 chk($sformatf("row%0d", i), obs(),
             {tbl[i].v, tbl[i].iv1, tbl[i].iv0, tbl[i].ec, tbl[i].en, tbl[i].busy});
      @(posedge clk); #1;
    end

    // configuration changed right after launch must not disturb the running nest
    begin
      logic [7:0] e0 [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
      logic [7:0] e1 [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
      logic [1:0] ee [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
      apply_cfg(a);
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      apply_cfg(junk);
      for (int i = 0; i < 6; i++) begin
        #1 chk($sformatf("cfg_frozen%0d", i), obs(),
               {1'b1, e1[i], e0[i], ee[i], (i == 5) ? 1'b1 : 1'b0, 1'b1});
        @(posedge clk); #1;
      end
      chk("cfg_frozen_done", obs(), {1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0});
      bus.start_i = 1'b0;
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of a run
    apply_cfg(a);
    bus.start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("pre_reset_run", obs(), {1'b1, 8'd0, 8'd2, 2'b01, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), 21'd0);
    bus.start_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", obs(), 21'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
